id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 203 ++++++++++++++++++++
 tb/tb_id_stage.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Decode stage of a 5-stage MIPS-I pipeline: field decode, load-use/branch
// hazard detection, branch/jump resolution with one delay slot, and the ID/EX register.
module id_stage (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_freeze,
  input  logic [31:0] i_instr_id,
  input  logic [31:0] i_cia_id,
  output logic [4:0]  o_rega_addr,
  output logic [4:0]  o_regb_addr,
  input  logic [31:0] i_rega_data,
  input  logic [31:0] i_regb_data,
  input  logic [4:0]  i_ex_dest,
  input  logic [4:0]  i_mem_dest,
  input  logic        i_ex_regwrite,
  input  logic        i_ex_memread,
  input  logic        i_mem_memread,
  output logic        o_taken_branch1,
  output logic [31:0] o_next_instruction_address,
  output logic        o_no_new_fetch,
  output logic        o_fetch_null2,
  output logic [31:0] o_instr_ex,
  output logic [31:0] o_cia_ex,
  output logic [31:0] o_opa_ex,
  output logic [31:0] o_opb_ex,
  output logic [31:0] o_imm_ex,
  output logic [4:0]  o_dest_ex,
  output logic        o_regwrite_ex,
  output logic        o_memread_ex,
  output logic        o_memwrite_ex,
  output logic [15:0] o_stall_count,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, REDIRECT = 2'd2} state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                         OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LW = 6'h23,
                         OP_SW = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08;

  state_t r_state, w_next_state;
  logic [15:0] r_stall_count;

  logic [5:0]  w_op;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [31:0] w_pc4, w_imm;
  logic        w_is_jr, w_is_beq, w_is_bne, w_is_j, w_is_jal, w_is_ctrl;
  logic        w_use_rs, w_use_rt, w_regwrite, w_memread, w_memwrite;
  logic [4:0]  w_dest;
  logic        w_ex_match, w_mem_match, w_load_use, w_branch_haz, w_hazard;
  logic        w_cond, w_taken, w_bubble;

  assign w_op  = i_instr_id[31:26];
  assign w_rs  = i_instr_id[25:21];
  assign w_rt  = i_instr_id[20:16];
  assign w_rd  = i_instr_id[15:11];
  assign w_pc4 = i_cia_id + 32'd4;

  assign w_is_jr   = (w_op == OP_RTYPE) && (i_instr_id[5:0] == FN_JR);
  assign w_is_beq  = (w_op == OP_BEQ);
  assign w_is_bne  = (w_op == OP_BNE);
  assign w_is_j    = (w_op == OP_J);
  assign w_is_jal  = (w_op == OP_JAL);
  assign w_is_ctrl = w_is_jr | w_is_beq | w_is_bne | w_is_j | w_is_jal;

  always_comb begin
    w_use_rs   = 1'b0;
    w_use_rt   = 1'b0;
    w_regwrite = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_dest     = 5'd0;
    case (w_op)
      OP_RTYPE: begin
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
        if (!w_is_jr) begin
          w_dest     = w_rd;
          w_regwrite = 1'b1;
        end
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI: begin
        w_use_rs   = 1'b1;
        w_dest     = w_rt;
        w_regwrite = 1'b1;
      end
      OP_LUI: begin
        w_dest     = w_rt;
        w_regwrite = 1'b1;
      end
      OP_LW: begin
        w_use_rs   = 1'b1;
        w_dest     = w_rt;
        w_regwrite = 1'b1;
        w_memread  = 1'b1;
      end
      OP_SW: begin
        w_use_rs   = 1'b1;
        w_use_rt   = 1'b1;
        w_memwrite = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
      end
      OP_JAL: begin
        w_dest     = 5'd31;
        w_regwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // A destination of r0 never creates a dependency.
  assign w_ex_match  = (i_ex_dest != 5'd0) &&
                       ((w_use_rs && i_ex_dest == w_rs) || (w_use_rt && i_ex_dest == w_rt));
  assign w_mem_match = (i_mem_dest != 5'd0) &&
                       ((w_use_rs && i_mem_dest == w_rs) || (w_use_rt && i_mem_dest == w_rt));
  assign w_load_use   = i_ex_memread && w_ex_match;
  assign w_branch_haz = (w_is_beq | w_is_bne | w_is_jr) &&
                        ((i_ex_regwrite && w_ex_match) || (i_mem_memread && w_mem_match));
  assign w_hazard     = w_load_use | w_branch_haz;

  assign w_cond  = w_is_j | w_is_jal | w_is_jr |
                   (w_is_beq && (i_rega_data == i_regb_data)) |
                   (w_is_bne && (i_rega_data != i_regb_data));
  assign w_taken = !w_hazard && (r_state != REDIRECT) && w_cond;
  // A control instruction sitting in the delay slot is squashed to a bubble.
  assign w_bubble = w_hazard || ((r_state == REDIRECT) && w_is_ctrl);

  always_comb begin
    o_next_instruction_address = w_pc4;
    if (w_is_beq || w_is_bne)
      o_next_instruction_address = w_pc4 + {{14{i_instr_id[15]}}, i_instr_id[15:0], 2'b00};
    else if (w_is_j || w_is_jal)
      o_next_instruction_address = {w_pc4[31:28], i_instr_id[25:0], 2'b00};
    else if (w_is_jr)
      o_next_instruction_address = i_rega_data;
  end

  assign w_imm = (w_op == OP_ANDI || w_op == OP_ORI) ? {16'd0, i_instr_id[15:0]}
                                                     : {{16{i_instr_id[15]}}, i_instr_id[15:0]};

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RUN, STALL: begin
        if (w_hazard)     w_next_state = STALL;
        else if (w_taken) w_next_state = REDIRECT;
        else              w_next_state = RUN;
      end
      REDIRECT: w_next_state = RUN;
      default:  w_next_state = RUN;
    endcase
  end

  // o_no_new_fetch is the hold back to IF: while high, IF and IF/ID keep their word.
  assign o_no_new_fetch  = w_hazard;
  assign o_fetch_null2   = (r_state == STALL) && !w_hazard;
  assign o_taken_branch1 = w_taken;
  assign o_rega_addr     = w_rs;
  assign o_regb_addr     = w_rt;
  assign o_stall_count   = r_stall_count;
  assign o_state         = r_state;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state       <= RUN;
      r_stall_count <= 16'd0;
    end else if (!i_freeze) begin
      r_state <= w_next_state;
      if (w_hazard && r_stall_count != 16'hFFFF)
        r_stall_count <= r_stall_count + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset || (!i_freeze && w_bubble)) begin
      o_instr_ex    <= 32'd0;
      o_cia_ex      <= 32'd0;
      o_opa_ex      <= 32'd0;
      o_opb_ex      <= 32'd0;
      o_imm_ex      <= 32'd0;
      o_dest_ex     <= 5'd0;
      o_regwrite_ex <= 1'b0;
      o_memread_ex  <= 1'b0;
      o_memwrite_ex <= 1'b0;
    end else if (!i_freeze) begin
      o_instr_ex    <= i_instr_id;
      o_cia_ex      <= i_cia_id;
      o_opa_ex      <= w_is_jal ? (i_cia_id + 32'd8) : i_rega_data;
      o_opb_ex      <= i_regb_data;
      o_imm_ex      <= w_imm;
      o_dest_ex     <= w_dest;
      o_regwrite_ex <= w_regwrite && (w_dest != 5'd0);
      o_memread_ex  <= w_memread;
      o_memwrite_ex <= w_memwrite;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus randomized decode traffic, all
// checked against an instruction-class reference model of the decode stage.
module tb_id_stage;

  logic        clk, reset, freeze;
  logic [31:0] instr_id, cia_id, rega_data, regb_data;
  logic [4:0]  rega_addr, regb_addr, ex_dest, mem_dest;
  logic        ex_regwrite, ex_memread, mem_memread;
  logic        taken, nnf, fnull;
  logic [31:0] next_addr, instr_ex, cia_ex, opa_ex, opb_ex, imm_ex;
  logic [4:0]  dest_ex;
  logic        regwrite_ex, memread_ex, memwrite_ex;
  logic [15:0] stall_count;
  logic [1:0]  state;

  id_stage dut (
    .i_clk(clk), .i_reset(reset), .i_freeze(freeze),
    .i_instr_id(instr_id), .i_cia_id(cia_id),
    .o_rega_addr(rega_addr), .o_regb_addr(regb_addr),
    .i_rega_data(rega_data), .i_regb_data(regb_data),
    .i_ex_dest(ex_dest), .i_mem_dest(mem_dest),
    .i_ex_regwrite(ex_regwrite), .i_ex_memread(ex_memread), .i_mem_memread(mem_memread),
    .o_taken_branch1(taken), .o_next_instruction_address(next_addr),
    .o_no_new_fetch(nnf), .o_fetch_null2(fnull),
    .o_instr_ex(instr_ex), .o_cia_ex(cia_ex), .o_opa_ex(opa_ex), .o_opb_ex(opb_ex),
    .o_imm_ex(imm_ex), .o_dest_ex(dest_ex), .o_regwrite_ex(regwrite_ex),
    .o_memread_ex(memread_ex), .o_memwrite_ex(memwrite_ex),
    .o_stall_count(stall_count), .o_state(state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int S_RUN = 0, S_STALL = 1, S_REDIRECT = 2;
  localparam int K_R = 0, K_JR = 1, K_ALUI = 2, K_ANDORI = 3, K_LUI = 4, K_LW = 5,
                 K_SW = 6, K_BEQ = 7, K_BNE = 8, K_J = 9, K_JAL = 10, K_OTHER = 11;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int          m_state;
  int          m_count;
  logic [31:0] m_regs [0:4];
  logic [4:0]  m_dest;
  logic        m_rw, m_mr, m_mw;

  // Model predictions for the current cycle
  logic        e_hazard, e_taken, e_fnull, e_bubble;
  logic [31:0] e_target;
  logic [31:0] e_n_regs [0:4];
  logic [4:0]  e_n_dest;
  logic        e_n_rw, e_n_mr, e_n_mw;

  // Combinational outputs sampled just before the edge
  logic        s_taken, s_nnf, s_fnull;
  logic [31:0] s_target;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int kind_of(input logic [31:0] ins);
    case (ins[31:26])
      6'h00:                return (ins[5:0] == 6'h08) ? K_JR : K_R;
      6'h08, 6'h09, 6'h0A:  return K_ALUI;
      6'h0C, 6'h0D:         return K_ANDORI;
      6'h0F:                return K_LUI;
      6'h23:                return K_LW;
      6'h2B:                return K_SW;
      6'h04:                return K_BEQ;
      6'h05:                return K_BNE;
      6'h02:                return K_J;
      6'h03:                return K_JAL;
      default:              return K_OTHER;
    endcase
  endfunction

  function automatic logic depends(input logic [4:0] d, input logic urs, input logic urt,
                                   input logic [4:0] rs, input logic [4:0] rt);
    return (d != 0) && ((urs && d == rs) || (urt && d == rt));
  endfunction

  task automatic model_comb();
    int k;
    logic urs, urt, has_dst, is_ctrl, cond;
    logic [4:0] rs, rt, dst;
    int off;
    k   = kind_of(instr_id);
    rs  = instr_id[25:21];
    rt  = instr_id[20:16];
    urs = !(k inside {K_J, K_JAL, K_LUI, K_OTHER});
    urt = k inside {K_R, K_JR, K_SW, K_BEQ, K_BNE};
    has_dst = k inside {K_R, K_ALUI, K_ANDORI, K_LUI, K_LW, K_JAL};
    dst = (k == K_R) ? instr_id[15:11] : (k == K_JAL) ? 5'd31 : rt;
    is_ctrl = k inside {K_JR, K_BEQ, K_BNE, K_J, K_JAL};
    e_hazard = (ex_memread && depends(ex_dest, urs, urt, rs, rt)) ||
               ((k inside {K_BEQ, K_BNE, K_JR}) &&
                ((ex_regwrite && depends(ex_dest, urs, urt, rs, rt)) ||
                 (mem_memread && depends(mem_dest, urs, urt, rs, rt))));
    cond = (k inside {K_J, K_JAL, K_JR}) || (k == K_BEQ && rega_data == regb_data) ||
           (k == K_BNE && rega_data != regb_data);
    e_taken  = !e_hazard && m_state != S_REDIRECT && cond;
    e_fnull  = (m_state == S_STALL) && !e_hazard;
    e_bubble = e_hazard || (m_state == S_REDIRECT && is_ctrl);
    off = $signed(instr_id[15:0]);
    if (k == K_BEQ || k == K_BNE)    e_target = cia_id + 32'd4 + 32'(off * 4);
    else if (k == K_J || k == K_JAL) e_target = ((cia_id + 32'd4) & 32'hF000_0000) |
                                                ({6'd0, instr_id[25:0]} << 2);
    else                             e_target = rega_data;
    e_n_regs[0] = instr_id;
    e_n_regs[1] = cia_id;
    e_n_regs[2] = (k == K_JAL) ? cia_id + 32'd8 : rega_data;
    e_n_regs[3] = regb_data;
    e_n_regs[4] = (k == K_ANDORI) ? {16'd0, instr_id[15:0]} : 32'(off);
    e_n_dest = has_dst ? dst : 5'd0;
    e_n_rw   = has_dst && dst != 0;
    e_n_mr   = (k == K_LW);
    e_n_mw   = (k == K_SW);
  endtask

  task automatic model_commit();
    if (!reset) begin
      m_state = S_RUN;
      m_count = 0;
      for (int i = 0; i < 5; i++) m_regs[i] = 32'd0;
      {m_dest, m_rw, m_mr, m_mw} = '0;
    end else if (!freeze) begin
      if (m_state == S_REDIRECT) m_state = S_RUN;
      else if (e_hazard)         m_state = S_STALL;
      else if (e_taken)          m_state = S_REDIRECT;
      else                       m_state = S_RUN;
      if (e_hazard && m_count < 65535) m_count = m_count + 1;
      if (e_bubble) begin
        for (int i = 0; i < 5; i++) m_regs[i] = 32'd0;
        {m_dest, m_rw, m_mr, m_mw} = '0;
      end else begin
        for (int i = 0; i < 5; i++) m_regs[i] = e_n_regs[i];
        {m_dest, m_rw, m_mr, m_mw} = {e_n_dest, e_n_rw, e_n_mr, e_n_mw};
      end
    end
  endtask

  // Driver: one clock with comb checks before the edge and register checks after it.
  task automatic step(input string tag);
    model_comb();
    #3;
    s_taken = taken; s_nnf = nnf; s_fnull = fnull; s_target = next_addr;
    chk({tag, ".rega_addr"}, 32'(rega_addr), 32'(instr_id[25:21]));
    chk({tag, ".regb_addr"}, 32'(regb_addr), 32'(instr_id[20:16]));
    chk({tag, ".no_new_fetch"}, 32'(nnf), 32'(e_hazard));
    chk({tag, ".fetchNull2"}, 32'(fnull), 32'(e_fnull));
    chk({tag, ".taken"}, 32'(taken), 32'(e_taken));
    if (e_taken) chk({tag, ".target"}, next_addr, e_target);
    @(posedge clk);
    model_commit();
    #1;
    chk({tag, ".state"}, 32'(state), 32'(m_state));
    chk({tag, ".stall_count"}, 32'(stall_count), 32'(m_count));
    chk({tag, ".instr_ex"}, instr_ex, m_regs[0]);
    chk({tag, ".cia_ex"}, cia_ex, m_regs[1]);
    chk({tag, ".opa_ex"}, opa_ex, m_regs[2]);
    chk({tag, ".opb_ex"}, opb_ex, m_regs[3]);
    chk({tag, ".imm_ex"}, imm_ex, m_regs[4]);
    chk({tag, ".ctl_ex"}, {24'd0, dest_ex, regwrite_ex, memread_ex, memwrite_ex},
        {24'd0, m_dest, m_rw, m_mr, m_mw});
  endtask

  task automatic clear_downstream();
    ex_dest = 0; mem_dest = 0; ex_regwrite = 0; ex_memread = 0; mem_memread = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] fn;
    rs  = 5'($urandom_range(0, 3));
    rt  = 5'($urandom_range(0, 3));
    rd  = 5'($urandom_range(0, 3));
    imm = 16'($urandom);
    fn  = 32'($urandom_range(0, 4));
    case ($urandom_range(0, 12))
      0, 1:    return {6'h00, rs, rt, rd, 5'd0, (fn == 0) ? 6'h20 : (fn == 1) ? 6'h22 :
                       (fn == 2) ? 6'h24 : (fn == 3) ? 6'h25 : 6'h2A};
      2:       return {6'h00, rs, 5'd0, 5'd0, 5'd0, 6'h08};
      3:       return {6'h08, rs, rt, imm};
      4:       return {6'h0C, rs, rt, imm};
      5:       return {6'h0D, rs, rt, imm};
      6:       return {6'h0F, 5'd0, rt, imm};
      7:       return {6'h23, rs, rt, imm};
      8:       return {6'h2B, rs, rt, imm};
      9:       return {6'h04, rs, rt, imm};
      10:      return {6'h05, rs, rt, imm};
      11:      return {6'h02, 26'($urandom)};
      default: return {6'h03, 26'($urandom)};
    endcase
  endfunction

  initial begin
    m_state = S_RUN;
    m_count = 0;
    for (int i = 0; i < 5; i++) m_regs[i] = 32'd0;
    {m_dest, m_rw, m_mr, m_mw} = '0;

    // Reset state, including reset with FREEZE high
    reset = 0; freeze = 0; instr_id = 32'h0; cia_id = 32'h0;
    rega_data = 32'h0; regb_data = 32'h0;
    clear_downstream();
    step("reset");
    freeze = 1; instr_id = 32'h2001_0005;
    step("reset_frz");
    reset = 1; freeze = 0;

    // Load-use: LW r5 in EX, ADD r6,r5,r1 in ID
    instr_id = {6'h00, 5'd5, 5'd1, 5'd6, 5'd0, 6'h20}; cia_id = 32'h200;
    rega_data = 32'h11; regb_data = 32'h22;
    ex_memread = 1; ex_dest = 5; ex_regwrite = 1;
    step("lduse1");
    chk("lduse.nnf", 32'(s_nnf), 32'd1);
    chk("lduse.bubble", instr_ex, 32'd0);
    chk("lduse.count", 32'(stall_count), 32'd1);
    clear_downstream();
    step("lduse2");
    chk("lduse.issue_opa", opa_ex, 32'h11);

    // Taken BEQ then ordinary delay slot
    instr_id = {6'h04, 5'd2, 5'd3, 16'd4}; cia_id = 32'h100;
    rega_data = 7; regb_data = 7;
    step("beq");
    chk("beq.taken", 32'(s_taken), 32'd1);
    chk("beq.target", s_target, 32'h114);
    chk("beq.redirect", 32'(state), 32'(S_REDIRECT));
    instr_id = {6'h08, 5'd1, 5'd4, 16'hFFFE}; cia_id = 32'h104;
    step("slot");
    chk("slot.issued", instr_ex, {6'h08, 5'd1, 5'd4, 16'hFFFE});
    chk("slot.imm", imm_ex, 32'hFFFF_FFFE);

    // JAL link and target, then taken-looking BEQ in its delay slot
    instr_id = {6'h03, 26'h0000010}; cia_id = 32'h0040_0000;
    step("jal");
    chk("jal.target", s_target, 32'h0000_0040);
    chk("jal.dest", 32'(dest_ex), 32'd31);
    chk("jal.opa", opa_ex, 32'h0040_0008);
    instr_id = {6'h04, 5'd1, 5'd1, 16'h0010}; cia_id = 32'h0040_0004;
    step("slot_beq");
    chk("slot_beq.taken", 32'(s_taken), 32'd0);
    chk("slot_beq.bubble", instr_ex, 32'd0);

    // LW r2 then BEQ r2,r3: stall on EX load, stall on MEM load, then resolve
    reset = 0;
    step("rst2");
    reset = 1;
    instr_id = {6'h04, 5'd2, 5'd3, 16'd4}; cia_id = 32'h300;
    ex_memread = 1; ex_regwrite = 1; ex_dest = 2;
    step("brh1");
    clear_downstream(); mem_memread = 1; mem_dest = 2;
    step("brh2");
    clear_downstream();
    step("brh3");
    chk("brh.taken", 32'(s_taken), 32'd1);
    chk("brh.fnull", 32'(s_fnull), 32'd1);
    chk("brh.count", 32'(stall_count), 32'd2);

    // Reset mid-stall with FREEZE high
    instr_id = {6'h00, 5'd5, 5'd1, 5'd6, 5'd0, 6'h20};
    ex_memread = 1; ex_dest = 5;
    step("stall_pre");
    reset = 0; freeze = 1;
    step("stall_rst");
    chk("stall_rst.state", 32'(state), 32'(S_RUN));
    chk("stall_rst.count", 32'(stall_count), 32'd0);
    reset = 1; freeze = 0;

    // Stall counter saturation
    for (int i = 0; i < 65540; i++) begin
      model_comb();
      @(posedge clk);
      model_commit();
      #1;
    end
    step("sat");
    chk("sat.count", 32'(stall_count), 32'hFFFF);
    clear_downstream();
    reset = 0;
    step("rst3");
    reset = 1;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      instr_id    = rand_instr();
      cia_id      = {$urandom} & 32'hFFFF_FFFC;
      rega_data   = $urandom_range(0, 3);
      regb_data   = ($urandom_range(0, 1) == 1) ? rega_data : 32'($urandom);
      ex_dest     = 5'($urandom_range(0, 3));
      mem_dest    = 5'($urandom_range(0, 3));
      ex_regwrite = 1'($urandom_range(0, 1));
      ex_memread  = ($urandom_range(0, 3) == 0);
      mem_memread = ($urandom_range(0, 3) == 0);
      freeze      = ($urandom_range(0, 7) == 0);
      reset       = ($urandom_range(0, 39) != 0);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
